// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer: streams one frame per hop from the MFCC window buffer downstream,
// then commands the next hop once the buffer has finished refilling.
module mfcc_frame_sequencer #(
    parameter int WIDTH      = 16,
    parameter int FRAME_SIZE = 306,
    parameter int IDXW       = $clog2(FRAME_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [15:0]      frame_limit_i,
    output logic             wb_start_move_o,
    output logic             wb_rd_en_o,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             wb_valid_i,
    input  logic             wb_idle_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic [IDXW-1:0]  sample_idx_o,
    output logic             sample_last_o,
    output logic [15:0]      frame_count_o,
    output logic             busy_o,
    output logic             done_o
);
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, WAIT_IDLE, MOVE, WAIT_ACK} state_t;
    localparam logic [IDXW:0]   FS       = (IDXW+1)'(FRAME_SIZE);
    localparam logic [IDXW:0]   FS_M1    = (IDXW+1)'(FRAME_SIZE - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_SIZE - 1);
    state_t        state, state_nx;
    logic [IDXW:0] rd_cnt;
    logic [15:0]   limit;
    logic          first_frame, last_fire, limit_hit;
    assign sample_last_o = sample_valid_o && sample_idx_o == LAST_IDX;
    assign last_fire     = sample_valid_o && sample_ready_i && sample_last_o;
    assign limit_hit     = limit != 16'd0 && frame_count_o == limit;
    assign busy_o        = state != IDLE;
    always_comb begin
        state_nx        = state;
        wb_rd_en_o      = 1'b0;
        wb_start_move_o = 1'b0;
        done_o          = 1'b0;
        case (state)
            IDLE:      if (enable_i) state_nx = first_frame ? STREAM : MOVE;
            STREAM: begin
                wb_rd_en_o = wb_valid_i && rd_cnt < FS && (!sample_valid_o || sample_ready_i);
                if (wb_rd_en_o && rd_cnt == FS_M1) state_nx = DRAIN;
            end
            DRAIN:     if (last_fire) state_nx = WAIT_IDLE;
            WAIT_IDLE: if (wb_idle_i) begin
                done_o   = limit_hit;
                state_nx = (limit_hit || !enable_i) ? IDLE : MOVE;
            end
            // hold the hop command off until the buffer is idle, so it never lands mid-refill
            MOVE: begin
                wb_start_move_o = wb_idle_i;
                if (wb_idle_i) state_nx = WAIT_ACK;
            end
            WAIT_ACK:  if (!wb_idle_i) state_nx = STREAM;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            first_frame    <= 1'b1;
            rd_cnt         <= '0;
            limit          <= '0;
            frame_count_o  <= '0;
            sample_o       <= '0;
            sample_idx_o   <= '0;
            sample_valid_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && enable_i) begin
                limit         <= frame_limit_i;
                frame_count_o <= '0;
                rd_cnt        <= '0;
            end
            if (wb_start_move_o) rd_cnt <= '0;
            if (wb_rd_en_o) begin
                sample_o     <= wb_data_i;
                sample_idx_o <= rd_cnt[IDXW-1:0];
                rd_cnt       <= rd_cnt + 1'b1;
            end
            sample_valid_o <= wb_rd_en_o || (sample_valid_o && !sample_ready_i);
            if (state == DRAIN && last_fire) begin
                first_frame <= 1'b0;
                if (frame_count_o != 16'hFFFF) frame_count_o <= frame_count_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// tb_mfcc_frame_sequencer: directed scenarios against a window-buffer model and an
// in-order expected-sample queue checked every cycle.
module tb_mfcc_frame_sequencer;
    localparam int FS = 8;
    localparam int W  = 16;
    localparam int IW = 3;
    logic          clk = 1'b0;
    logic          rst_n, enable, ready, gate;
    logic [15:0]   limit;
    logic          wb_start_move, wb_rd_en, wb_valid, wb_idle;
    logic [W-1:0]  wb_data, sample;
    logic          sample_valid, sample_last, busy, done;
    logic [IW-1:0] sample_idx;
    logic [15:0]   frame_count;

    mfcc_frame_sequencer #(.WIDTH(W), .FRAME_SIZE(FS)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .frame_limit_i(limit),
        .wb_start_move_o(wb_start_move), .wb_rd_en_o(wb_rd_en), .wb_data_i(wb_data),
        .wb_valid_i(wb_valid), .wb_idle_i(wb_idle), .sample_o(sample),
        .sample_valid_o(sample_valid), .sample_ready_i(ready), .sample_idx_o(sample_idx),
        .sample_last_o(sample_last), .frame_count_o(frame_count), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // window buffer: sample value encodes hop number and position; refills for 5 cycles per hop
    logic [7:0] hop;
    logic [3:0] ptr;
    int         refill;
    assign wb_idle  = refill == 0;
    assign wb_valid = refill == 0 && ptr < 4'(FS) && gate;
    assign wb_data  = 16'h1000 + {hop, 8'h00} + {12'h000, ptr};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hop <= '0; ptr <= '0; refill <= 0;
        end else if (wb_start_move) begin
            hop <= hop + 1'b1; ptr <= '0; refill <= 5;
        end else begin
            if (refill != 0) refill <= refill - 1;
            if (wb_rd_en) ptr <= ptr + 1'b1;
        end
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0]   q_data[$];
    logic [IW-1:0] q_idx[$];
    int            cyc = 0, hs_cnt, move_cnt, done_cnt, first_hs_cyc, last_hs_cyc;
    logic [15:0]   exp_fc, first_acc, last_acc;
    logic [IW-1:0] first_idx;
    logic          prev_stall = 1'b0;
    logic [15:0]   prev_data;
    logic [IW-1:0] prev_idx;

    task automatic reset_counts;
        hs_cnt = 0; move_cnt = 0; done_cnt = 0; first_hs_cyc = -1; last_hs_cyc = -1; exp_fc = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q_data.delete(); q_idx.delete(); prev_stall = 1'b0;
        end else begin
            if (sample_valid) begin
                chk("out_pending", q_data.size() != 0, 1);
                if (q_data.size() != 0) begin
                    chk("sample_data", sample, q_data[0]);
                    chk("sample_idx", sample_idx, q_idx[0]);
                    chk("sample_last", sample_last, q_idx[0] == IW'(FS - 1));
                end
            end else
                chk("no_lost_sample", q_data.size(), 0);
            if (prev_stall) begin
                chk("stall_valid", sample_valid, 1);
                chk("stall_data", sample, prev_data);
                chk("stall_idx", sample_idx, prev_idx);
            end
            if (wb_rd_en) chk("rd_en_gated", wb_valid && ptr < 4'(FS), 1);
            if (wb_start_move) begin
                chk("move_while_idle", wb_idle, 1);
                move_cnt++;
            end
            if (done) done_cnt++;
            if (busy) chk("frame_count", frame_count, exp_fc);
            prev_stall = sample_valid && !ready;
            prev_data  = sample;
            prev_idx   = sample_idx;
            if (sample_valid && ready && q_data.size() != 0) begin
                if (first_hs_cyc < 0) begin
                    first_hs_cyc = cyc; first_acc = sample; first_idx = sample_idx;
                end
                last_hs_cyc = cyc;
                last_acc    = sample;
                hs_cnt++;
                if (q_idx[0] == IW'(FS - 1)) exp_fc++;
                void'(q_data.pop_front());
                void'(q_idx.pop_front());
            end
            if (wb_rd_en) begin
                q_data.push_back(wb_data);
                q_idx.push_back(ptr[IW-1:0]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_sample"}, sample, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_idx"}, sample_idx, 0);
        chk({tag, "_last"}, sample_last, 0);
        chk({tag, "_fc"}, frame_count, 0);
        chk({tag, "_strobes"}, {wb_start_move, wb_rd_en, done}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin tick; n++; end
        chk({tag, "_done_seen"}, done, 1);
        enable = 1'b0;
        repeat (3) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b0; limit = 16'd0; ready = 1'b0; gate = 1'b1;
        reset_counts;
        repeat (2) tick;
        check_quiet("por");
        rst_n = 1'b1;
        tick;

        // reset in the middle of the very first frame
        ready = 1'b1; enable = 1'b1;
        n = 0;
        while (!(sample_valid && sample_idx == 3'd5) && n < 50) begin tick; n++; end
        chk("midreset_reach", sample_idx, 5);
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        enable = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;

        // single frame, limit 1: restarts at idx 0 with no hop
        limit = 16'd1; reset_counts; enable = 1'b1;
        wait_done("single");
        chk("single_hs", hs_cnt, 8);
        chk("single_span", last_hs_cyc - first_hs_cyc, 7);
        chk("single_first_idx", first_idx, 0);
        chk("single_first", first_acc, 16'h1000);
        chk("single_last", last_acc, 16'h1007);
        chk("single_moves", move_cnt, 0);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_fc", frame_count, 1);
        chk("single_busy", busy, 0);

        // unlimited run of three hops, stopped during the third frame
        limit = 16'd0; reset_counts; enable = 1'b1;
        n = 0;
        while (move_cnt < 3 && n < 300) begin tick; n++; end
        chk("unlim_moves_reached", move_cnt, 3);
        enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick; n++; end
        chk("unlim_idle", busy, 0);
        chk("unlim_moves", move_cnt, 3);
        chk("unlim_fc", frame_count, 3);
        chk("unlim_hs", hs_cnt, 24);
        chk("unlim_done", done_cnt, 0);
        chk("unlim_last", last_acc, 16'h1307);

        // random downstream backpressure over two frames
        limit = 16'd2; reset_counts; enable = 1'b1;
        n = 0;
        while (!done && n < 600) begin
            ready = 1'($urandom_range(0, 1));
            tick;
            n++;
        end
        chk("bp_done_seen", done, 1);
        enable = 1'b0; ready = 1'b1;
        repeat (3) tick;
        chk("bp_hs", hs_cnt, 16);
        chk("bp_moves", move_cnt, 2);
        chk("bp_fc", frame_count, 2);
        chk("bp_done", done_cnt, 1);

        // buffer underflow right after sample 3 is read
        limit = 16'd1; reset_counts; enable = 1'b1;
        n = 0;
        while (!(ptr == 4'd4 && busy) && n < 100) begin tick; n++; end
        chk("uf_reach", ptr, 4);
        gate = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("uf_rd_en", wb_rd_en, 0);
            tick;
        end
        gate = 1'b1;
        #1;
        chk("uf_resume_rd", wb_rd_en, 1);
        chk("uf_resume_pos", ptr, 4);
        wait_done("uf");
        chk("uf_hs", hs_cnt, 8);

        // stop during a frame, then re-enable
        limit = 16'd0; reset_counts; enable = 1'b1;
        n = 0;
        while (!(sample_valid && sample_idx == 3'd2 && move_cnt == 1) && n < 100) begin tick; n++; end
        chk("stop_reach", sample_idx, 2);
        enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick; n++; end
        chk("stop_idle", busy, 0);
        chk("stop_hs", hs_cnt, 8);
        chk("stop_fc", frame_count, 1);
        chk("stop_done", done_cnt, 0);
        limit = 16'd1; reset_counts; enable = 1'b1;
        n = 0;
        while (!wb_start_move && !wb_rd_en && n < 50) begin tick; n++; end
        chk("reen_move_first", wb_start_move, 1);
        chk("reen_no_read", wb_rd_en, 0);
        wait_done("reen");
        chk("reen_moves", move_cnt, 1);
        chk("reen_fc", frame_count, 1);
        chk("reen_hs", hs_cnt, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
